// File: rtl/division.sv
// Multicycle unsigned restoring divider: one quotient bit per clock, start/busy/done
// handshake, and the shared ALU {N,Z,C,V} flag vector.
module division #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] c,
  output logic [n-1:0] r,
  output logic [3:0]   banderas
);

  localparam int cw = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_next;
  logic [cw-1:0] count;
  logic [n:0]    rem;
  logic [n-1:0]  quo;
  logic [n-1:0]  div;

  logic [n:0]    rem_shift;
  logic [n:0]    rem_step;
  logic [n-1:0]  quo_step;
  logic          fits;

  // One restoring step: shift {rem, quo} left, then subtract the divisor if it fits.
  always_comb begin
    rem_shift = {rem[n-1:0], quo[n-1]};
    fits      = rem[n] | (rem_shift >= {1'b0, div});
    rem_step  = rem_shift;
    quo_step  = {quo[n-2:0], 1'b0};
    if (fits) begin
      rem_step = rem_shift - {1'b0, div};
      quo_step = {quo[n-2:0], 1'b1};
    end
  end

  // The divide-by-zero path spends its first DONE cycle latching results (done still low).
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (b != '0) ? CALC : DONE;
      CALC: if (count == cw'(1)) state_next = DONE;
      DONE: if (done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      div      <= '0;
      done     <= 1'b0;
      c        <= '0;
      r        <= '0;
      banderas <= 4'b0000;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem   <= '0;
            quo   <= a;
            div   <= b;
            count <= cw'(n);
          end
        end
        CALC: begin
          rem   <= rem_step;
          quo   <= quo_step;
          count <= count - 1'b1;
          if (count == cw'(1)) begin
            c        <= quo_step;
            r        <= rem_step[n-1:0];
            banderas <= {1'b0, (quo_step == '0), 2'b00};
            done     <= 1'b1;
          end
        end
        DONE: begin
          if (!done) begin
            c        <= '1;
            r        <= quo;
            banderas <= 4'b0001;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_division.sv
// Directed self-checking bench for the division unit at n=4 (with exhaustive sweep)
// and a single n=8 vector.
module tb_division;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4;
  logic [3:0] c4, r4, flags4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8;
  logic [7:0] c8, r8;
  logic [3:0] flags8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  division #(.n(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .c(c4), .r(r4), .banderas(flags4)
  );

  division #(.n(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .c(c8), .r(r8), .banderas(flags8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge, then waits (bounded) for done while counting busy cycles.
  task automatic applyStimulus(input logic [3:0] ai, input logic [3:0] bi,
                               output int lat, output int busyCnt);
    @(negedge clk);
    a4 = ai; b4 = bi; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    checkOutput("busy_after_start", 32'(busy4), 32'd1);
    lat = 0;
    busyCnt = 1;
    while (done4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy4 === 1'b1) busyCnt++;
    end
  endtask

  task automatic checkResult(input logic [3:0] ai, input logic [3:0] bi,
                             input int lat, input int busyCnt);
    logic [3:0] ec, er, ef;
    int el;
    if (bi == 4'd0) begin
      ec = 4'hF; er = ai; ef = 4'b0001; el = 1;
    end else begin
      ec = ai / bi; er = ai % bi; ef = {1'b0, (ec == 4'd0), 2'b00}; el = 4;
    end
    checkOutput("latency", 32'(lat), 32'(el));
    checkOutput("busy_cycles", 32'(busyCnt), 32'(el + 1));
    checkOutput("quotient", 32'(c4), 32'(ec));
    checkOutput("remainder", 32'(r4), 32'(er));
    checkOutput("banderas", 32'(flags4), 32'(ef));
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done4), 32'd0);
    checkOutput("idle_after_done", 32'(busy4), 32'd0);
  endtask

  initial begin
    int lat, busyCnt, extraDone;

    repeat (2) @(negedge clk);
    checkOutput("reset_c", 32'(c4), 32'd0);
    checkOutput("reset_r", 32'(r4), 32'd0);
    checkOutput("reset_flags", 32'(flags4), 32'd0);
    checkOutput("reset_busy", 32'(busy4), 32'd0);
    checkOutput("reset_done", 32'(done4), 32'd0);
    rst_n = 1'b1;

    applyStimulus(4'd13, 4'd4, lat, busyCnt);
    checkResult(4'd13, 4'd4, lat, busyCnt);
    applyStimulus(4'd3, 4'd7, lat, busyCnt);
    checkResult(4'd3, 4'd7, lat, busyCnt);
    applyStimulus(4'd15, 4'd1, lat, busyCnt);
    checkResult(4'd15, 4'd1, lat, busyCnt);
    applyStimulus(4'd9, 4'd0, lat, busyCnt);
    checkResult(4'd9, 4'd0, lat, busyCnt);

    // start and operand changes mid-operation must be ignored
    @(negedge clk);
    a4 = 4'd13; b4 = 4'd4; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd2; b4 = 4'd1;
    @(negedge clk);
    start4 = 1'b0; a4 = 4'd7; b4 = 4'd5;
    lat = 2;
    while (done4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("inflight_latency", 32'(lat), 32'd4);
    checkOutput("inflight_c", 32'(c4), 32'd3);
    checkOutput("inflight_r", 32'(r4), 32'd1);
    extraDone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4 === 1'b1) extraDone++;
    end
    checkOutput("no_queued_start", 32'(extraDone), 32'd0);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    a4 = 4'd14; b4 = 4'd3; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_c", 32'(c4), 32'd0);
    checkOutput("async_rst_r", 32'(r4), 32'd0);
    checkOutput("async_rst_flags", 32'(flags4), 32'd0);
    checkOutput("async_rst_busy", 32'(busy4), 32'd0);
    checkOutput("async_rst_done", 32'(done4), 32'd0);
    extraDone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done4 === 1'b1) extraDone++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done4 === 1'b1) extraDone++;
    end
    checkOutput("abandoned_no_done", 32'(extraDone), 32'd0);
    applyStimulus(4'd10, 4'd3, lat, busyCnt);
    checkResult(4'd10, 4'd3, lat, busyCnt);

    // n=8 instance
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd16; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("n8_latency", 32'(lat), 32'd8);
    checkOutput("n8_c", 32'(c8), 32'd15);
    checkOutput("n8_r", 32'(r8), 32'd15);
    checkOutput("n8_flags", 32'(flags8), 32'd0);

    // exhaustive n=4 sweep, including every divide-by-zero case
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        applyStimulus(4'(ai), 4'(bi), lat, busyCnt);
        checkResult(4'(ai), 4'(bi), lat, busyCnt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
